// File: rtl/abofs_dispatch_ctrl_if.sv
// rtl/abofs_dispatch_ctrl_if.sv - command/offset/finish handshake bundle for abofs_dispatch_ctrl
// Optional o_stall_cnt appears only under ABOFS_STALL_CNT_EN.
interface abofs_dispatch_ctrl_if #(
  parameter int OFS_BW  = 32,
  parameter int ND      = 5,
  parameter int NBLK_BW = 16
);
  logic               cfg_rdy;
  logic               cfg_ack;
  logic [NBLK_BW-1:0] i_cfg_nblk;
  logic [ND-1:0]      i_cfg_dmask;
  logic               src_rdy;
  logic               src_ack;
  logic [OFS_BW-1:0]  i_src_ofs;
  logic [ND-1:0]      dst_rdy;
  logic [ND-1:0]      dst_ack;
  logic [OFS_BW-1:0]  o_dst_ofs;
  logic               fin_rdy;
  logic               fin_ack;
`ifdef ABOFS_STALL_CNT_EN
  logic [31:0]        o_stall_cnt;
`endif

  modport slave (
    input  cfg_rdy, i_cfg_nblk, i_cfg_dmask, src_rdy, i_src_ofs, dst_ack, fin_ack,
    output cfg_ack, src_ack, dst_rdy, o_dst_ofs, fin_rdy
`ifdef ABOFS_STALL_CNT_EN
    , output o_stall_cnt
`endif
  );

  modport master (
    output cfg_rdy, i_cfg_nblk, i_cfg_dmask, src_rdy, i_src_ofs, dst_ack, fin_ack,
    input  cfg_ack, src_ack, dst_rdy, o_dst_ofs, fin_rdy
`ifdef ABOFS_STALL_CNT_EN
    , input o_stall_cnt
`endif
  );
endinterface

// File: rtl/abofs_dispatch_ctrl.sv
// rtl/abofs_dispatch_ctrl.sv - broadcasts looper block offsets to ND consumers for one pass
// Optional stall counter enabled by ABOFS_STALL_CNT_EN.
module abofs_dispatch_ctrl #(
  parameter int OFS_BW  = 32,
  parameter int ND      = 5,
  parameter int NBLK_BW = 16
) (
  input logic                  i_clk,
  input logic                  i_rst,
  abofs_dispatch_ctrl_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_e;

  state_e             state_q, state_d;
  logic [NBLK_BW-1:0] nblk_q, nblk_d;
  logic [NBLK_BW-1:0] acc_cnt_q, acc_cnt_d;
  logic [NBLK_BW-1:0] done_cnt_q, done_cnt_d;
  logic [ND-1:0]      dmask_q, dmask_d;
  logic [ND-1:0]      pend_q, pend_d;
  logic               full_q, full_d;
  logic [OFS_BW-1:0]  ofs_q, ofs_d;

  logic               cfg_xfer, src_xfer, fin_xfer;
  logic               complete, discard, finishing;
  logic [ND-1:0]      hit;
  logic [NBLK_BW:0]   done_next;

  assign hit       = (state_q == S_RUN && full_q) ? (pend_q & bus.dst_ack) : '0;
  assign complete  = (state_q == S_RUN) && full_q && ((pend_q & ~hit) == '0);
  assign cfg_xfer  = bus.cfg_rdy && bus.cfg_ack;
  assign src_xfer  = bus.src_rdy && bus.src_ack;
  assign fin_xfer  = bus.fin_rdy && bus.fin_ack;
  // With an empty mask an accepted offset is retired in the same cycle.
  assign discard   = src_xfer && (dmask_q == '0);
  assign done_next = {1'b0, done_cnt_q} + {{NBLK_BW{1'b0}}, (complete || discard)};
  assign finishing = (complete || discard) && (done_next == {1'b0, nblk_q});

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cfg_xfer) state_d = (bus.i_cfg_nblk == '0) ? S_FIN : S_RUN;
      S_RUN:   if (finishing) state_d = S_FIN;
      S_FIN:   if (fin_xfer) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.cfg_ack = 1'b0;
    bus.src_ack = 1'b0;
    bus.fin_rdy = 1'b0;
    bus.dst_rdy = '0;
    case (state_q)
      S_IDLE: bus.cfg_ack = bus.cfg_rdy;
      S_RUN: begin
        bus.dst_rdy = full_q ? pend_q : '0;
        bus.src_ack = bus.src_rdy && (acc_cnt_q < nblk_q) && (!full_q || complete);
      end
      S_FIN:   bus.fin_rdy = 1'b1;
      default: ;
    endcase
  end

  assign bus.o_dst_ofs = ofs_q;

  always_comb begin
    nblk_d     = nblk_q;
    dmask_d    = dmask_q;
    acc_cnt_d  = acc_cnt_q;
    done_cnt_d = done_cnt_q;
    pend_d     = pend_q;
    full_d     = full_q;
    ofs_d      = ofs_q;
    if (cfg_xfer) begin
      nblk_d     = bus.i_cfg_nblk;
      dmask_d    = bus.i_cfg_dmask;
      acc_cnt_d  = '0;
      done_cnt_d = '0;
      pend_d     = '0;
      full_d     = 1'b0;
    end else if (state_q == S_RUN) begin
      pend_d     = pend_q & ~hit;
      done_cnt_d = done_next[NBLK_BW-1:0];
      if (complete) full_d = 1'b0;
      // A reload in the completing cycle overrides the drain above.
      if (src_xfer) begin
        ofs_d     = bus.i_src_ofs;
        acc_cnt_d = acc_cnt_q + {{(NBLK_BW-1){1'b0}}, 1'b1};
        pend_d    = dmask_q;
        full_d    = |dmask_q;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      nblk_q     <= '0;
      dmask_q    <= '0;
      acc_cnt_q  <= '0;
      done_cnt_q <= '0;
      pend_q     <= '0;
      full_q     <= 1'b0;
      ofs_q      <= '0;
    end else begin
      nblk_q     <= nblk_d;
      dmask_q    <= dmask_d;
      acc_cnt_q  <= acc_cnt_d;
      done_cnt_q <= done_cnt_d;
      pend_q     <= pend_d;
      full_q     <= full_d;
      ofs_q      <= ofs_d;
    end
  end

`ifdef ABOFS_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (cfg_xfer)
      stall_cnt_d = '0;
    else if (state_q == S_RUN && full_q && hit == '0 && stall_cnt_q != 32'hFFFF_FFFF)
      stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign bus.o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_abofs_dispatch_ctrl.sv
// tb/tb_abofs_dispatch_ctrl.sv - directed bench with a counting reference model for abofs_dispatch_ctrl
module tb_abofs_dispatch_ctrl;
  localparam int OFS_BW  = 32;
  localparam int ND      = 5;
  localparam int NBLK_BW = 16;
  localparam int P_IDLE = 0, P_RUN = 1, P_FIN = 2;

  logic i_clk = 1'b0;
  logic i_rst = 1'b0;
  always #5 i_clk = ~i_clk;

  abofs_dispatch_ctrl_if #(.OFS_BW(OFS_BW), .ND(ND), .NBLK_BW(NBLK_BW)) bus ();

  abofs_dispatch_ctrl #(.OFS_BW(OFS_BW), .ND(ND), .NBLK_BW(NBLK_BW)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (bus)
  );

  int pass_cnt = 0;
  int chk_cnt  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: actual=%0h expected=%0h at %0t", name, got, exp, $time);
  endtask

  // stimulus configuration, written by the main sequence only
  logic [31:0] src_vals [8];
  int          src_n = 0;
  int          dly [ND];
  int          fin_dly = 0;

  // observed transfers, written by the model process only
  logic          cfg_x = 0, src_x = 0, fin_x = 0;
  logic [ND-1:0] dst_x = '0;
  int cyc = 0, st_src = 0, st_dst0 = 0, st_fin_hi = 0, st_mid = 0;
  int cfg_cyc = 0, fin_cyc = 0, src_last_cyc = 0;
  bit fin_seen = 0;

  // reference model: counts of accepted offsets and per-consumer deliveries
  int            ph;
  int            m_nblk, m_acc, m_done;
  int            m_dlv [ND];
  logic [ND-1:0] m_mask, e_rdy, e_hit;
  logic [31:0]   m_ofs;
  longint        m_stall;
  logic          e_cfg, e_src, e_fin, all_ok;

  // environment: looper, consumers and finish sink
  initial begin
    int src_idx;
    int dcnt [ND];
    int fcnt;
    src_idx = 0;
    fcnt = 0;
    foreach (dcnt[k]) dcnt[k] = 0;
    bus.src_rdy = 1'b0;
    bus.i_src_ofs = '0;
    bus.dst_ack = '0;
    bus.fin_ack = 1'b0;
    forever begin
      @(posedge i_clk);
      #1;
      if (!i_rst || cfg_x) src_idx = 0;
      else if (src_x) src_idx++;
      bus.src_rdy = (src_idx < src_n);
      if (src_idx < src_n) bus.i_src_ofs = src_vals[src_idx];
      for (int k = 0; k < ND; k++) begin
        if (!i_rst || dst_x[k]) dcnt[k] = 0;
        bus.dst_ack[k] = bus.dst_rdy[k] && (dcnt[k] == dly[k]);
        if (bus.dst_rdy[k]) dcnt[k]++;
      end
      if (!i_rst || fin_x) fcnt = 0;
      bus.fin_ack = bus.fin_rdy && (fcnt == fin_dly);
      if (bus.fin_rdy) fcnt++;
    end
  end

  // per-cycle compare against the model, then advance the model
  initial begin
    ph = P_IDLE; m_nblk = 0; m_acc = 0; m_done = 0; m_mask = '0; m_ofs = '0; m_stall = 0;
    foreach (m_dlv[k]) m_dlv[k] = 0;
    forever begin
      @(negedge i_clk);
      cyc++;
      if (!i_rst) begin
        ph = P_IDLE; m_acc = 0; m_nblk = 0; m_mask = '0; m_ofs = '0; m_stall = 0;
        foreach (m_dlv[k]) m_dlv[k] = 0;
      end
      for (int k = 0; k < ND; k++)
        e_rdy[k] = (ph == P_RUN) && m_mask[k] && (m_dlv[k] < m_acc);
      e_hit = e_rdy & bus.dst_ack;
      all_ok = 1'b1;
      for (int k = 0; k < ND; k++)
        if (m_mask[k] && (m_dlv[k] + (e_hit[k] ? 1 : 0) < m_acc)) all_ok = 1'b0;
      e_cfg = (ph == P_IDLE) && bus.cfg_rdy;
      e_src = (ph == P_RUN) && bus.src_rdy && (m_acc < m_nblk) && all_ok;
      e_fin = (ph == P_FIN);

      check("cfg_ack", bus.cfg_ack, e_cfg);
      check("src_ack", bus.src_ack, e_src);
      check("dst_rdy", bus.dst_rdy, e_rdy);
      check("fin_rdy", bus.fin_rdy, e_fin);
      check("o_dst_ofs", bus.o_dst_ofs, m_ofs);
`ifdef ABOFS_STALL_CNT_EN
      check("o_stall_cnt", bus.o_stall_cnt, m_stall);
`endif

      cfg_x = bus.cfg_rdy && bus.cfg_ack;
      src_x = bus.src_rdy && bus.src_ack;
      fin_x = bus.fin_rdy && bus.fin_ack;
      dst_x = bus.dst_rdy & bus.dst_ack;
      if (cfg_x) begin cfg_cyc = cyc; fin_seen = 0; end
      if (src_x) begin st_src++; src_last_cyc = cyc; end
      if (dst_x[0]) st_dst0++;
      if (|bus.dst_rdy[3:1]) st_mid++;
      if (bus.fin_rdy) begin
        st_fin_hi++;
        if (!fin_seen) begin fin_seen = 1; fin_cyc = cyc; end
      end

      if (i_rst) begin
        case (ph)
          P_IDLE: if (e_cfg) begin
            m_nblk = int'(bus.i_cfg_nblk);
            m_mask = bus.i_cfg_dmask;
            m_acc = 0;
            m_stall = 0;
            foreach (m_dlv[k]) m_dlv[k] = 0;
            ph = (m_nblk == 0) ? P_FIN : P_RUN;
          end
          P_RUN: begin
            if (e_rdy != '0 && e_hit == '0 && m_stall < 64'hFFFF_FFFF) m_stall++;
            for (int k = 0; k < ND; k++) if (e_hit[k]) m_dlv[k]++;
            if (e_src) begin m_acc++; m_ofs = bus.i_src_ofs; end
            m_done = m_acc;
            for (int k = 0; k < ND; k++) if (m_mask[k] && m_dlv[k] < m_done) m_done = m_dlv[k];
            if (m_done == m_nblk) ph = P_FIN;
          end
          default: if (bus.fin_ack) ph = P_IDLE;
        endcase
      end
    end
  end

  int s_src, s_dst0, s_fin, s_mid;
  int d_src, d_dst0, d_fin, d_mid;

  task automatic run_pass(input int nblk, input logic [ND-1:0] mask, input int nofs,
                          input int d_dma, input int fdly);
    int n;
    for (int i = 0; i < nofs; i++) src_vals[i] = 32'h10 * (i + 1);
    src_n = nofs;
    foreach (dly[k]) dly[k] = 0;
    dly[2] = d_dma;
    fin_dly = fdly;
    s_src = st_src; s_dst0 = st_dst0; s_fin = st_fin_hi; s_mid = st_mid;
    @(posedge i_clk);
    #1;
    bus.cfg_rdy = 1'b1;
    bus.i_cfg_nblk = NBLK_BW'(nblk);
    bus.i_cfg_dmask = mask;
    for (n = 0; n < 20; n++) begin
      @(negedge i_clk);
      if (bus.cfg_ack) break;
    end
    check("cfg_wait", bus.cfg_ack, 1'b1);
    @(posedge i_clk);
    #1;
    bus.cfg_rdy = 1'b0;
    for (n = 0; n < 300; n++) begin
      @(negedge i_clk);
      if (bus.fin_rdy && bus.fin_ack) break;
    end
    check("fin_wait", bus.fin_rdy && bus.fin_ack, 1'b1);
    repeat (2) @(posedge i_clk);
    #1;
    d_src = st_src - s_src; d_dst0 = st_dst0 - s_dst0;
    d_fin = st_fin_hi - s_fin; d_mid = st_mid - s_mid;
  endtask

  initial begin
    int n;
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    bus.cfg_rdy = 1'b0;
    bus.i_cfg_nblk = '0;
    bus.i_cfg_dmask = '0;
    foreach (dly[k]) dly[k] = 0;
    #3;
    check("rst_dst_rdy", bus.dst_rdy, 5'b0);
    check("rst_src_ack", bus.src_ack, 1'b0);
    check("rst_fin_rdy", bus.fin_rdy, 1'b0);
    check("rst_o_dst_ofs", bus.o_dst_ofs, 32'h0);
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;

    run_pass(3, 5'b11111, 3, 0, 0);
    check("basic_src", d_src, 3);
    check("basic_dst0", d_dst0, 3);
    check("basic_fin_lat", fin_cyc - cfg_cyc, 5);
    check("basic_last_src", src_last_cyc - cfg_cyc, 3);

    run_pass(2, 5'b11111, 2, 4, 0);
    check("stag_src", d_src, 2);
    check("stag_reload_cyc", src_last_cyc - cfg_cyc, 6);
    check("stag_dst0", d_dst0, 2);
    check("stag_fin_lat", fin_cyc - cfg_cyc, 12);

    run_pass(2, 5'b10001, 2, 0, 0);
    check("mask_mid_rdy", d_mid, 0);
    check("mask_dst0", d_dst0, 2);
    check("mask_fin_lat", fin_cyc - cfg_cyc, 4);

    run_pass(4, 5'b00000, 4, 0, 0);
    check("zmask_src", d_src, 4);
    check("zmask_last_src", src_last_cyc - cfg_cyc, 4);
    check("zmask_dst0", d_dst0, 0);
    check("zmask_fin_lat", fin_cyc - cfg_cyc, 5);

    run_pass(0, 5'b11111, 3, 0, 0);
    check("zblk_src", d_src, 0);
    check("zblk_fin_lat", fin_cyc - cfg_cyc, 1);

    run_pass(3, 5'b11111, 5, 0, 10);
    check("limit_src", d_src, 3);
    check("limit_fin_hold", d_fin, 11);
    check("limit_fin_lat", fin_cyc - cfg_cyc, 5);

    for (int i = 0; i < 2; i++) src_vals[i] = 32'hA0 + 32'(i);
    src_n = 2;
    foreach (dly[k]) dly[k] = 0;
    dly[2] = 50;
    fin_dly = 0;
    @(posedge i_clk);
    #1;
    bus.cfg_rdy = 1'b1;
    bus.i_cfg_nblk = 16'd2;
    bus.i_cfg_dmask = 5'b00100;
    @(posedge i_clk);
    #1;
    bus.cfg_rdy = 1'b0;
    for (n = 0; n < 10; n++) begin
      if (bus.dst_rdy == 5'b00100) break;
      @(posedge i_clk);
      #1;
    end
    check("ar_pre_rdy", bus.dst_rdy, 5'b00100);
    #1;
    i_rst = 1'b0;
    #1;
    check("ar_dst_rdy", bus.dst_rdy, 5'b0);
    check("ar_src_ack", bus.src_ack, 1'b0);
    check("ar_fin_rdy", bus.fin_rdy, 1'b0);
    check("ar_cfg_ack", bus.cfg_ack, 1'b0);
    check("ar_o_dst_ofs", bus.o_dst_ofs, 32'h0);
`ifdef ABOFS_STALL_CNT_EN
    check("ar_stall_cnt", bus.o_stall_cnt, 32'h0);
`endif
    src_n = 0;
    @(posedge i_clk);
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    bus.cfg_rdy = 1'b1;
    #1;
    check("ar_cfg_ack_after", bus.cfg_ack, 1'b1);
    bus.cfg_rdy = 1'b0;

    run_pass(3, 5'b11111, 3, 0, 0);
    check("resume_src", d_src, 3);
    check("resume_fin_lat", fin_cyc - cfg_cyc, 5);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
